// File: rtl/pll_rst_seq.sv
// pll_rst_seq: PLL reset sequencer running on the free-running reference clock.
// Pulses the PLL's active-high reset, waits for its asynchronous locked flag to
// stay high for a qualifying interval, then releases the downstream reset.
// Lock loss in RUN re-sequences; lock timeouts retry and eventually latch FAULT.
// Optional feature: define PLL_RST_SEQ_SW_REQ_EN to add the sw_req input, a
// level-sampled synchronous request that restarts the sequence from any state
// (including FAULT). There is no valid/ready handshake on this block: sw_req
// acts on every edge where it is sampled high.
module pll_rst_seq #(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int MAX_RETRIES         = 3,
  parameter int CNT_W               = 8
) (
  input  logic             refclk,
  input  logic             rst_n,
  input  logic             pll_locked,
`ifdef PLL_RST_SEQ_SW_REQ_EN
  input  logic             sw_req,
`endif
  output logic             pll_rst,
  output logic             sys_rst_n,
  output logic [2:0]       state_o,
  output logic             fault,
  output logic [CNT_W-1:0] loss_cnt,
  output logic [CNT_W-1:0] retry_cnt
);

  localparam logic [2:0] S_RESET_PLL = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK = 3'd1;
  localparam logic [2:0] S_STABLE    = 3'd2;
  localparam logic [2:0] S_RUN       = 3'd3;
  localparam logic [2:0] S_FAULT     = 3'd4;

  // cnt is shared by the reset pulse and the stable-lock qualification.
  localparam int CNT_MAX = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES
                                                                 : LOCK_STABLE_CYCLES;
  localparam int CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int TW = (LOCK_TIMEOUT_CYCLES > 1) ? $clog2(LOCK_TIMEOUT_CYCLES) : 1;

  localparam logic [CW-1:0]    RST_LAST      = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0]    STB_LAST      = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TW-1:0]    TMO_LAST      = TW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] RETRY_LIMIT   = CNT_W'(MAX_RETRIES);
  localparam logic [CNT_W-1:0] CNT_ONES      = '1;
  // MAX_RETRIES == 0 means retry forever.
  localparam bit               RETRY_LIMITED = (MAX_RETRIES != 0);

  logic             sync_q;
  logic             locked_s;
  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic [TW-1:0]    tmo;
  logic [TW-1:0]    tmo_nxt;
  logic [CNT_W-1:0] loss_nxt;
  logic [CNT_W-1:0] retry_nxt;

  assign state_o = state;

  // Two-flop synchronizer for the asynchronous PLL locked flag.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync_q   <= pll_locked;
      locked_s <= sync_q;
    end
  end

  // Next-state logic; a timeout outranks the STABLE->RUN qualification.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    tmo_nxt   = tmo;
    loss_nxt  = loss_cnt;
    retry_nxt = retry_cnt;
    case (state)
      S_RESET_PLL: begin
        if (cnt == RST_LAST) begin
          state_nxt = S_WAIT_LOCK;
          cnt_nxt   = '0;
          tmo_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      S_WAIT_LOCK, S_STABLE: begin
        // tmo spans both states: chatter in STABLE does not restart it.
        tmo_nxt = tmo + TW'(1);
        if (tmo == TMO_LAST) begin
          retry_nxt = (retry_cnt == CNT_ONES) ? retry_cnt : retry_cnt + CNT_W'(1);
          cnt_nxt   = '0;
          tmo_nxt   = '0;
          state_nxt = (RETRY_LIMITED && (retry_cnt == RETRY_LIMIT)) ? S_FAULT : S_RESET_PLL;
        end else if (state == S_WAIT_LOCK) begin
          if (locked_s) begin
            state_nxt = S_STABLE;
            cnt_nxt   = '0;
          end
        end else if (!locked_s) begin
          state_nxt = S_WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == STB_LAST) begin
          state_nxt = S_RUN;
          cnt_nxt   = '0;
          retry_nxt = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      S_RUN: begin
        if (!locked_s) begin
          state_nxt = S_RESET_PLL;
          cnt_nxt   = '0;
          loss_nxt  = (loss_cnt == CNT_ONES) ? loss_cnt : loss_cnt + CNT_W'(1);
        end
      end
      S_FAULT: begin
        state_nxt = S_FAULT;
      end
      default: begin
        state_nxt = S_RESET_PLL;
        cnt_nxt   = '0;
      end
    endcase
`ifdef PLL_RST_SEQ_SW_REQ_EN
    // Software restart wins over everything; the loss history is preserved.
    if (sw_req) begin
      state_nxt = S_RESET_PLL;
      cnt_nxt   = '0;
      tmo_nxt   = '0;
      retry_nxt = '0;
      loss_nxt  = loss_cnt;
    end
`endif
  end

  // State, counters and registered outputs; pll_rst/fault track the state entered.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_RESET_PLL;
      cnt       <= '0;
      tmo       <= '0;
      loss_cnt  <= '0;
      retry_cnt <= '0;
      pll_rst   <= 1'b1;
      sys_rst_n <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      tmo       <= tmo_nxt;
      loss_cnt  <= loss_nxt;
      retry_cnt <= retry_nxt;
      pll_rst   <= (state_nxt == S_RESET_PLL) || (state_nxt == S_FAULT);
      fault     <= (state_nxt == S_FAULT);
      sys_rst_n <= (state == S_RUN);
    end
  end

endmodule
